dffsre_chain_ift: RTL and testbench

- Parametrised successor to the single-bit set/clear/enable flip-flop IFT test block.
- A DEPTH-stage, WIDTH-bit shift chain with synchronous set, clear and enable.
- Carries a TW-bit information-flow taint label per stage alongside the data.
- Used as an IFT regression target for multi-bit, multi-stage sequential taint propagation. Also serves as the reference register-chain primitive for tainted pipelines.

---
 rtl/dffsre_chain_ift.sv | 85 ++++++++
 tb/tb_dffsre_chain_ift.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dffsre_chain_ift.sv
// DEPTH-stage, WIDTH-bit shift chain with synchronous clear/set/enable and per-stage IFT taint labels.
// Optional `DFFSRE_CHAIN_PRECISE_EN: EN_t/CLK_t only taint a stage whose next value would differ under EN.
module dffsre_chain_ift #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 3,
    parameter int TW    = 32
) (
    input  logic                       CLK,
    input  logic [TW-1:0]              CLK_t,
    input  logic                       CLR_N,
    input  logic [TW-1:0]              CLR_t,
    input  logic                       SET,
    input  logic [TW-1:0]              SET_t,
    input  logic                       EN,
    input  logic [TW-1:0]              EN_t,
    input  logic [WIDTH-1:0]           D,
    input  logic [TW-1:0]              D_t,
    output logic [WIDTH-1:0]           Q,
    output logic [TW-1:0]              Q_t,
    output logic [$clog2(DEPTH+1)-1:0] FILL,
    output logic                       FULL
);

    localparam int FW = $clog2(DEPTH + 1);
    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] data_q;
    logic [DEPTH-1:0][TW-1:0]    taint_q;
    logic [FW-1:0]               fill_q;

    logic [DEPTH-1:0][WIDTH-1:0] src_d;
    logic [DEPTH-1:0][TW-1:0]    src_t;
    logic [DEPTH-1:0][TW-1:0]    stage_ct;

    for (genvar g = 0; g < DEPTH; g++) begin : g_src
        if (g == 0) begin : g_head
            assign src_d[g] = D;
            assign src_t[g] = D_t;
        end else begin : g_body
            assign src_d[g] = data_q[g-1];
            assign src_t[g] = taint_q[g-1];
        end

`ifdef DFFSRE_CHAIN_PRECISE_EN
        // EN only influences this stage when shifting would actually change its value
        assign stage_ct[g] = CLR_t | SET_t | ((src_d[g] != data_q[g]) ? (EN_t | CLK_t) : '0);
`else
        assign stage_ct[g] = CLK_t | CLR_t | SET_t | EN_t;
`endif
    end

    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i]  <= '0;
                taint_q[i] <= CLR_t;
            end
            fill_q <= '0;
        end else if (SET) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i]  <= '1;
                taint_q[i] <= CLK_t | CLR_t | SET_t;
            end
            fill_q <= FILL_MAX;
        end else if (EN) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i]  <= src_d[i];
                taint_q[i] <= src_t[i] | stage_ct[i];
            end
            if (fill_q != FILL_MAX) begin
                fill_q <= fill_q + 1'b1;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                taint_q[i] <= taint_q[i] | stage_ct[i];
            end
        end
    end

    assign Q    = data_q[DEPTH-1];
    assign Q_t  = taint_q[DEPTH-1];
    assign FILL = fill_q;
    assign FULL = (fill_q == FILL_MAX);

endmodule

// File: tb/tb_dffsre_chain_ift.sv
// Self-checking bench for dffsre_chain_ift: vector table, hand-written corner sequences, random vs queue model.
module tb_dffsre_chain_ift;

    localparam int WIDTH = 4;
    localparam int DEPTH = 3;
    localparam int TW    = 32;
    localparam int FW    = $clog2(DEPTH + 1);

    logic             CLK = 1'b0;
    logic [TW-1:0]    CLK_t = '0;
    logic             CLR_N = 1'b0;
    logic [TW-1:0]    CLR_t = '0;
    logic             SET = 1'b0;
    logic [TW-1:0]    SET_t = '0;
    logic             EN = 1'b0;
    logic [TW-1:0]    EN_t = '0;
    logic [WIDTH-1:0] D = '0;
    logic [TW-1:0]    D_t = '0;
    logic [WIDTH-1:0] Q;
    logic [TW-1:0]    Q_t;
    logic [FW-1:0]    FILL;
    logic             FULL;

    int n_checks = 0;
    int n_fail   = 0;

    dffsre_chain_ift #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TW(TW)) dut (
        .CLK(CLK), .CLK_t(CLK_t), .CLR_N(CLR_N), .CLR_t(CLR_t), .SET(SET), .SET_t(SET_t),
        .EN(EN), .EN_t(EN_t), .D(D), .D_t(D_t), .Q(Q), .Q_t(Q_t), .FILL(FILL), .FULL(FULL)
    );

    always #5 CLK = ~CLK;

    // Reference model: queues with index 0 = stage 0, back = output stage
    logic [WIDTH-1:0] md[$];
    logic [TW-1:0]    mt[$];
    int               mfill = 0;

    task automatic model_update();
        logic [TW-1:0]    fixed;
        logic [TW-1:0]    ctrl;
        logic [WIDTH-1:0] nd[$];
        logic [TW-1:0]    nt[$];
        if (!CLR_N) begin
            md = {}; mt = {};
            for (int i = 0; i < DEPTH; i++) begin md.push_back('0); mt.push_back(CLR_t); end
            mfill = 0;
        end else if (SET) begin
            md = {}; mt = {};
            for (int i = 0; i < DEPTH; i++) begin md.push_back('1); mt.push_back(CLK_t | CLR_t | SET_t); end
            mfill = DEPTH;
        end else begin
            fixed = CLR_t | SET_t;
            nd = md;
            nd.push_front(D);
            nt = mt;
            nt.push_front(D_t);
            // nd/nt now hold each stage's shift source at the same index
            for (int i = 0; i < DEPTH; i++) begin
`ifdef DFFSRE_CHAIN_PRECISE_EN
                ctrl = (nd[i] != md[i]) ? (EN_t | CLK_t) : '0;
`else
                ctrl = EN_t | CLK_t;
`endif
                if (EN) mt[i] = nt[i] | fixed | ctrl;
                else    mt[i] = mt[i] | fixed | ctrl;
            end
            if (EN) begin
                md.push_front(D);
                void'(md.pop_back());
                mfill = (mfill + 1 > DEPTH) ? DEPTH : mfill + 1;
            end
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [WIDTH-1:0] q, input logic [TW-1:0] qt,
                             input int fill, input logic full);
        check({tag, ".Q"},    64'(Q),    64'(q));
        check({tag, ".Q_t"},  64'(Q_t),  64'(qt));
        check({tag, ".FILL"}, 64'(FILL), 64'(fill));
        check({tag, ".FULL"}, 64'(FULL), 64'(full));
    endtask

    task automatic tick();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic drive(input logic clr_n, input logic set, input logic en, input logic [WIDTH-1:0] d,
                         input logic [TW-1:0] d_t, input logic [TW-1:0] clr_t, input logic [TW-1:0] set_t,
                         input logic [TW-1:0] en_t, input logic [TW-1:0] clk_t);
        CLR_N = clr_n; SET = set; EN = en; D = d; D_t = d_t;
        CLR_t = clr_t; SET_t = set_t; EN_t = en_t; CLK_t = clk_t;
    endtask

    typedef struct {
        logic             clr_n, set, en;
        logic [WIDTH-1:0] d;
        logic [TW-1:0]    d_t, clr_t, set_t;
        logic [WIDTH-1:0] q;
        logic [TW-1:0]    q_t;
        int               fill;
        logic             full;
    } vec_t;

    function automatic vec_t mk(logic clr_n, logic set, logic en, logic [WIDTH-1:0] d, logic [TW-1:0] d_t,
                                logic [TW-1:0] clr_t, logic [TW-1:0] set_t, logic [WIDTH-1:0] q,
                                logic [TW-1:0] q_t, int fill, logic full);
        vec_t v;
        v.clr_n = clr_n; v.set = set; v.en = en; v.d = d; v.d_t = d_t; v.clr_t = clr_t; v.set_t = set_t;
        v.q = q; v.q_t = q_t; v.fill = fill; v.full = full;
        return v;
    endfunction

    vec_t tbl[9];
    logic [TW-1:0] exp_t;

    initial begin
        tbl[0] = mk(0, 1, 1, 4'h0, 0, 32'h0,  0,     4'h0, 32'h0,  0, 0); // reset beats set/en
        tbl[1] = mk(1, 0, 1, 4'hA, 1, 0,      0,     4'h0, 32'h0,  1, 0);
        tbl[2] = mk(1, 0, 1, 4'h5, 2, 0,      0,     4'h0, 32'h0,  2, 0);
        tbl[3] = mk(1, 0, 1, 4'h3, 4, 0,      0,     4'hA, 32'h1,  3, 1);
        tbl[4] = mk(1, 0, 1, 4'h0, 0, 0,      0,     4'h5, 32'h2,  3, 1); // fill saturates
        tbl[5] = mk(1, 1, 1, 4'h0, 0, 0,      32'h8, 4'hF, 32'h8,  3, 1);
        tbl[6] = mk(1, 0, 0, 4'h0, 0, 0,      0,     4'hF, 32'h8,  3, 1);
        tbl[7] = mk(0, 1, 0, 4'h0, 0, 32'h20, 32'h8, 4'h0, 32'h20, 0, 0); // clear beats set
        tbl[8] = mk(1, 0, 1, 4'h1, 0, 0,      0,     4'h0, 32'h20, 1, 0); // sticky reset taint shifts

        #2;
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].clr_n, tbl[i].set, tbl[i].en, tbl[i].d, tbl[i].d_t, tbl[i].clr_t, tbl[i].set_t, 0, 0);
            tick();
            check_all($sformatf("vec%0d", i), tbl[i].q, tbl[i].q_t, tbl[i].fill, tbl[i].full);
        end

        // Reset mid-operation: two shifts, clear with EN high, then three shifts to FULL
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 1, 4'h7, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 1, 4'h9, 0, 0, 0, 0, 0); tick();
        check("mid.FILL2", 64'(FILL), 64'd2);
        drive(0, 0, 1, 4'hE, 0, 0, 0, 0, 0); tick();
        check_all("mid.clr", 4'h0, 32'h0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            drive(1, 0, 1, 4'(i), 0, 0, 0, 0, 0); tick();
            check($sformatf("mid.full%0d", i), 64'(FULL), 64'(i == 3));
        end
        check("mid.Q", 64'(Q), 64'h1);

        // Hold with tainted EN, last two stages differing (5 at output, 3 behind it)
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 1, 4'h5, 2, 0, 0, 0, 0); tick();
        drive(1, 0, 1, 4'h3, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 1, 4'h6, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 4'h0, 0, 0, 0, 32'h10, 0); tick(); tick();
        check_all("hold.diff", 4'h5, 32'h12, 3, 1);

        // Hold with the last two stages equal
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 1, 4'h5, 2, 0, 0, 0, 0); tick();
        drive(1, 0, 1, 4'h5, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 1, 4'h6, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 4'h0, 0, 0, 0, 32'h10, 0); tick(); tick();
`ifdef DFFSRE_CHAIN_PRECISE_EN
        exp_t = 32'h2;
`else
        exp_t = 32'h12;
`endif
        check_all("hold.same", 4'h5, exp_t, 3, 1);

        // Randomised phase against the queue model
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 15) != 0), ($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
                  4'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                  ($urandom_range(0, 1) == 1) ? (32'h1 << $urandom_range(0, 31)) : 32'h0,
                  ($urandom_range(0, 7) == 0) ? $urandom : 32'h0,
                  ($urandom_range(0, 7) == 0) ? $urandom : 32'h0,
                  ($urandom_range(0, 7) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0,
                  ($urandom_range(0, 15) == 0) ? (32'h1 << $urandom_range(0, 31)) : 32'h0);
            tick();
            check_all($sformatf("rnd%0d", n), md[DEPTH-1], mt[DEPTH-1], mfill, mfill == DEPTH);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
